// File: rtl/mc_datapath.sv
// mc_datapath: FSM-sequenced multi-cycle MIPS-subset datapath.
// Optional PERF_CNT_EN adds saturating cycle and retire counters.
module mc_datapath #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retire_cnt
`endif
);

    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic              req_q, req_d, we_q, we_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [5:0]        op, funct;
    logic [RW-1:0]     rs, rt, rd;
    logic [DATA_W-1:0] imm, alu_res;
    logic              is_r, is_addi, is_lw, is_sw, is_beq, is_halt, is_nop;
    logic              unused_bits;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];
    assign rs    = ir_q[21 +: RW];
    assign rt    = ir_q[16 +: RW];
    assign rd    = ir_q[11 +: RW];
    assign imm   = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign unused_bits = ^ir_q[10:6];

    assign is_r    = (op == 6'h00) &&
                     (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                      funct == 6'h25 || funct == 6'h2A);
    assign is_addi = (op == 6'h08);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_halt = (op == 6'h3F);
    assign is_nop  = !(is_r || is_addi || is_lw || is_sw || is_beq || is_halt);

    assign imem_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign alu_out    = alu_q;
    assign halted     = (state_q == S_HALT);

    // ALU: R-type by funct, address/immediate add, compare for BEQ
    always_comb begin
        alu_res = '0;
        if (is_r) begin
            case (funct)
                6'h20:   alu_res = a_q + b_q;
                6'h22:   alu_res = a_q - b_q;
                6'h24:   alu_res = a_q & b_q;
                6'h25:   alu_res = a_q | b_q;
                6'h2A:   alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
                default: alu_res = '0;
            endcase
        end else if (is_addi || is_lw || is_sw) begin
            alu_res = a_q + imm;
        end else if (is_beq) begin
            alu_res = a_q - b_q;
        end
    end

    // Next-state and datapath register updates for each FSM state
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        req_d    = req_q;
        we_d     = we_q;
        rf_we    = 1'b0;
        rf_waddr = is_r ? rd : rt;
        rf_wdata = is_lw ? mdr_q : alu_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = imem_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d = (rs == '0) ? '0 : regs_q[rs];
                b_d = (rt == '0) ? '0 : regs_q[rt];
                if (is_halt)     state_d = S_HALT;
                else if (is_nop) state_d = S_FETCH;
                else             state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (is_beq) begin
                    if (a_q == b_q) pc_d = pc_q + imm[PC_W-1:0];
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    req_d   = 1'b1;
                    we_d    = is_sw;
                    addr_d  = alu_res;
                    wdata_d = b_q;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (is_lw) begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Control and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
        end
    end

    // Register file: single write port, register 0 never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != '0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

`ifdef PERF_CNT_EN
    logic retire;
    assign retire = (state_q == S_DECODE && (is_nop || is_halt)) ||
                    (state_q == S_EXEC && is_beq) ||
                    (state_q == S_MEM && dmem_ready && is_sw) ||
                    (state_q == S_WB);

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state_q != S_HALT && cycle_cnt != 32'hFFFF_FFFF)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (retire && retire_cnt != 32'hFFFF_FFFF)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed program runs against mc_datapath with a
// data-memory transaction scoreboard and register/PC checks.
module tb_mc_datapath;

    localparam int DW = 32;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata, alu_out;
    logic          dmem_req, dmem_we, dmem_ready, halted;

    logic [31:0] rom [32];

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   req_cycles = 0;

    mc_datapath #(.DATA_W(DW), .PC_W(PW), .NUM_REGS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .alu_out    (alu_out),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input logic [5:0] op, input int rs,
                                        input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] r_t(input logic [5:0] fn, input int rd,
                                        input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 32; i++) rom[i] = 32'hFC00_0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Data-memory monitor: handshake completes at the next rising edge
    always @(negedge clk) begin : mon
        txn_t t;
        if (dmem_req === 1'b1) req_cycles++;
        if (dmem_req === 1'b1 && dmem_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_txn", 32'(sb.size()), 32'd1);
            end else begin
                t = sb.pop_front();
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, t.we});
                chk("dmem_addr", dmem_addr, t.addr);
                if (t.we) chk("dmem_wdata", dmem_wdata, t.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset state and basic ALU program ----
        fill_rom();
        rom[0] = i_t(6'h08, 0, 1, 5);
        rom[1] = i_t(6'h08, 0, 2, 7);
        rom[2] = r_t(6'h20, 3, 1, 2);
        reset = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = '0;
        @(posedge clk);
        #1;
        chk("rst_pc", 32'(imem_addr), 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_daddr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_alu", alu_out, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        tick(4);
        chk("p1_r1", dut.regs_q[1], 32'd5);
        chk("p1_pc1", 32'(imem_addr), 32'd1);
        tick(4);
        chk("p1_r2", dut.regs_q[2], 32'd7);
        tick(4);
        chk("p1_r3", dut.regs_q[3], 32'd12);
        chk("p1_alu", alu_out, 32'd12);
        tick(1);
        chk("p1_halt13", {31'd0, halted}, 32'd0);
        tick(1);
        chk("p1_halt14", {31'd0, halted}, 32'd1);
        chk("p1_pc4", 32'(imem_addr), 32'd4);
        tick(3);
        chk("p1_halt_hold", {31'd0, halted}, 32'd1);
        chk("p1_pc_hold", 32'(imem_addr), 32'd4);

        // ---- 2: store with 3 wait cycles, then load ----
        rom[3] = i_t(6'h2B, 0, 3, 4);
        rom[4] = i_t(6'h23, 0, 4, 4);
        do_reset();
        tick(12);
        chk("p2_r3", dut.regs_q[3], 32'd12);
        dmem_ready = 1'b0;
        dmem_rdata = 32'd12;
        req_cycles = 0;
        sb.push_back('{we: 1'b1, addr: 32'd4, wdata: 32'd12});
        tick(3);
        chk("p2_req_on", {31'd0, dmem_req}, 32'd1);
        chk("p2_we", {31'd0, dmem_we}, 32'd1);
        chk("p2_addr", dmem_addr, 32'd4);
        chk("p2_wdata", dmem_wdata, 32'd12);
        tick(3);
        chk("p2_req_wait", {31'd0, dmem_req}, 32'd1);
        chk("p2_addr_stable", dmem_addr, 32'd4);
        sb.push_back('{we: 1'b0, addr: 32'd4, wdata: 32'd0});
        dmem_ready = 1'b1;
        tick(1);
        chk("p2_req_off", {31'd0, dmem_req}, 32'd0);
        chk("p2_req_cycles", 32'(req_cycles), 32'd4);
        tick(4);
        chk("p2_r4_before_wb", dut.regs_q[4], 32'd0);
        tick(1);
        chk("p2_r4", dut.regs_q[4], 32'd12);
        chk("p2_pc5", 32'(imem_addr), 32'd5);
        chk("p2_alu_addr", alu_out, 32'd4);
        tick(2);
        chk("p2_halted", {31'd0, halted}, 32'd1);

        // ---- 3a: taken branch back onto itself ----
        fill_rom();
        rom[0] = i_t(6'h08, 0, 1, 5);
        rom[1] = i_t(6'h08, 0, 2, 7);
        rom[2] = i_t(6'h04, 1, 1, -1);
        do_reset();
        tick(8);
        chk("p3_pc2", 32'(imem_addr), 32'd2);
        tick(2);
        chk("p3_pc_fetched", 32'(imem_addr), 32'd3);
        tick(1);
        chk("p3_beq_taken", 32'(imem_addr), 32'd2);
        tick(3);
        chk("p3_beq_loop", 32'(imem_addr), 32'd2);

        // ---- 3b: branch not taken ----
        rom[2] = i_t(6'h04, 1, 2, 5);
        do_reset();
        tick(11);
        chk("p3_beq_nt", 32'(imem_addr), 32'd3);
        chk("p3_nt_run", {31'd0, halted}, 32'd0);
        tick(2);
        chk("p3_nt_halt", {31'd0, halted}, 32'd1);

        // ---- 4: r0 write, SUB wrap, signed SLT, AND/OR ----
        fill_rom();
        rom[0] = i_t(6'h08, 0, 1, 5);
        rom[1] = i_t(6'h08, 0, 2, 7);
        rom[2] = i_t(6'h08, 0, 0, 9);
        rom[3] = r_t(6'h22, 5, 1, 2);
        rom[4] = r_t(6'h2A, 6, 5, 1);
        rom[5] = r_t(6'h20, 7, 0, 1);
        rom[6] = r_t(6'h24, 8, 1, 2);
        rom[7] = r_t(6'h25, 9, 1, 2);
        do_reset();
        tick(12);
        chk("p4_alu9", alu_out, 32'd9);
        chk("p4_r0", dut.regs_q[0], 32'd0);
        tick(4);
        chk("p4_sub", dut.regs_q[5], 32'hFFFF_FFFE);
        tick(4);
        chk("p4_slt", dut.regs_q[6], 32'd1);
        tick(4);
        chk("p4_r0_read", dut.regs_q[7], 32'd5);
        tick(4);
        chk("p4_and", dut.regs_q[8], 32'd5);
        tick(4);
        chk("p4_or", dut.regs_q[9], 32'd7);
        tick(2);
        chk("p4_halted", {31'd0, halted}, 32'd1);

        // ---- 5: NOPs to PC 31, illegal op, PC wrap ----
        for (int i = 0; i < 31; i++) rom[i] = 32'h0000_0000;
        rom[31] = 32'hF800_0000;
        do_reset();
        tick(62);
        chk("p5_pc31", 32'(imem_addr), 32'd31);
        tick(2);
        chk("p5_wrap", 32'(imem_addr), 32'd0);
        chk("p5_not_halted", {31'd0, halted}, 32'd0);
        chk("p5_alu_idle", alu_out, 32'd0);
        tick(1);
        chk("p5_pc1", 32'(imem_addr), 32'd1);

        // ---- 6: reset during a load wait ----
        fill_rom();
        rom[0] = i_t(6'h08, 0, 4, 3);
        rom[1] = i_t(6'h23, 0, 4, 8);
        do_reset();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h55;
        tick(4);
        chk("p6_r4", dut.regs_q[4], 32'd3);
        tick(3);
        chk("p6_req", {31'd0, dmem_req}, 32'd1);
        chk("p6_we", {31'd0, dmem_we}, 32'd0);
        chk("p6_addr", dmem_addr, 32'd8);
        tick(2);
        chk("p6_req_wait", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("p6_req_async", {31'd0, dmem_req}, 32'd0);
        chk("p6_addr_clr", dmem_addr, 32'd0);
        chk("p6_pc_clr", 32'(imem_addr), 32'd0);
        chk("p6_r4_no_load", dut.regs_q[4], 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dmem_ready = 1'b1;
        chk("p6_pc_restart", 32'(imem_addr), 32'd0);
        tick(1);
        chk("p6_pc1", 32'(imem_addr), 32'd1);
        tick(3);
        chk("p6_r4_again", dut.regs_q[4], 32'd3);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle datapath. It has a configurable PC width, a configurable data width and an FSM-sequenced instruction flow (FETCH/DECODE/EXEC/MEM/WB). It adds a ready-handshaked data-memory port, immediate, branch and halt support. It sits between the instruction ROM and the data memory, and exports the ALU result for observation.

Parameters:
DATA_W, 32, datapath, register and ALU width (>=16)
PC_W, 5, instruction-word address width; PC counts words
NUM_REGS, 32, register file depth (power of 2, <=32); reg 0 reads 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_addr  output  PC_W  instruction word address (= PC)
imem_data  input  32  instruction word, combinational from imem_addr
dmem_addr  output  DATA_W  data word address (ALU result)
dmem_wdata  output  DATA_W  store data
dmem_req  output  1  memory request, held high until accepted
dmem_we  output  1  1 = store, 0 = load; valid while dmem_req
dmem_ready  input  1  request accepted (store) / rdata valid (load) this cycle
dmem_rdata  input  DATA_W  load data, sampled when dmem_req & dmem_ready
alu_out  output  DATA_W  registered ALU result of the last EXEC
halted  output  1  core stopped after HALT

Behaviour:
- Reset (async, active-high): PC=0; state=FETCH; all registers, IR, alu_out, dmem_* = 0; halted=0. Asserting reset mid-operation aborts any pending request: dmem_req falls immediately and no writeback occurs.
- Instruction format: MIPS-style. op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0] sign-extended to DATA_W. Register indices are truncated to log2(NUM_REGS) bits.
- Supported instructions:
  - R-type (op 0): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed).
  - ADDI 0x08; LW 0x23; SW 0x2B; BEQ 0x04; HALT 0x3F.
  - Any other op or funct is a NOP: no register or memory change, PC advances.
- FSM, one state per cycle unless noted:
  - FETCH: IR <= imem_data; PC <= PC+1 (mod 2^PC_W).
  - DECODE: A <= R[rs]; B <= R[rt]. HALT goes to HALTED. NOP goes to FETCH.
  - EXEC: alu_out <= the op result; LW/SW address = A+imm.
  - BEQ: if A==B then PC <= PC+imm (truncated to PC_W, wraps), then FETCH.
  - MEM: drive dmem_req; stay in MEM until dmem_ready. SW then goes to FETCH. LW latches rdata, then goes to WB.
  - WB: write rd (R-type), rt (ADDI) or the load data (LW). Writes to reg 0 are discarded. Then FETCH.
  - HALTED: terminal; halted=1, no outputs change. Only reset exits.
- Cycles per instruction with zero-wait memory (dmem_ready high in the first MEM cycle): R/ADDI 4, LW 5, SW 4, BEQ 3, NOP 2. Each wait cycle adds 1.
- Arithmetic: results wrap modulo 2^DATA_W and no carry is kept. SLT yields 1 or 0.
- dmem_addr, dmem_wdata and dmem_we stay stable for the whole time dmem_req is high.
- The register file has a single write port; writes happen only in WB, so there are no read/write hazards.

Optional Feature:
PERF_CNT_EN.
- Defined: the module adds outputs cycle_cnt[31:0] and retire_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-HALTED cycle.
  - retire_cnt increments on the last cycle of every instruction, including NOPs.
  - Both saturate at 0xFFFFFFFF.
- Undefined: neither port nor the counter logic exists.

Test Plan:
1. Reset then ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT -> r3=12, alu_out=12, halted=1 at cycle 14; PC=4.
2. SW r3,4(r0) with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with addr=4, wdata=12, we=1. Then LW r4,4(r0) with rdata=12 -> r4=12.
3. BEQ r1,r1,-1 at PC=2 -> PC returns to 2; branch takes 3 cycles. BEQ with r1!=r2 -> PC=3.
4. ADDI r0,r0,9 -> r0 stays 0. SUB r5,r1,r2 (5-7) -> 0xFFFFFFFE. SLT r6,r5,r1 -> 1.
5. Illegal op 0x3E at PC=31 -> 2-cycle NOP; PC wraps to 0.
6. Reset asserted during a MEM wait -> dmem_req drops asynchronously; the LW target register is unchanged. After release, fetch restarts at PC=0.
